// File: rtl/vga_sync_generator_if.sv
// Timing bundle between the VGA sync generator and its downstream consumer
// (Color_Manager and the VGA output pins).
interface vga_sync_generator_if #(
  parameter int COUNTER_WIDTH = 10
);
   logic                     Enable;
   logic                     Pixel_Tick;
   logic                     HSync;
   logic                     VSync;
   logic                     Video_On;
   logic [COUNTER_WIDTH-1:0] H_Count;
   logic [COUNTER_WIDTH-1:0] V_Count;
   logic                     Frame_Start;
   logic [15:0]              Frame_Count;

   modport master (
      input  Enable,
      output Pixel_Tick, HSync, VSync, Video_On, H_Count, V_Count, Frame_Start, Frame_Count
   );

   modport slave (
      output Enable,
      input  Pixel_Tick, HSync, VSync, Video_On, H_Count, V_Count, Frame_Start, Frame_Count
   );
endinterface

// File: rtl/vga_sync_generator.sv
// VGA HSync/VSync and pixel/line position generator, counted in divided pixel ticks.
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN.
module vga_sync_generator #(
  parameter int CLK_DIV       = 4,
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int COUNTER_WIDTH = 10,
  parameter bit SYNC_POLARITY = 1'b0
) (
   input  logic               Clk_i,
   input  logic               Rst_i,
   vga_sync_generator_if.master vga_io
);
   localparam int CW      = COUNTER_WIDTH;
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0]    H_VIS    = CW'(H_VISIBLE);
   localparam logic [CW-1:0]    V_VIS    = CW'(V_VISIBLE);
   localparam logic [CW-1:0]    HS_START = CW'(H_VISIBLE + H_FRONT);
   localparam logic [CW-1:0]    HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0]    VS_START = CW'(V_VISIBLE + V_FRONT);
   localparam logic [CW-1:0]    VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic             ACT      = SYNC_POLARITY;

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CW-1:0]    h_q, h_d, v_q, v_d;
   logic             tick_q, tick_d, hs_q, hs_d, vs_q, vs_d;
   logic             von_q, von_d, fs_q, fs_d;
   logic             run_d, tick_now, frame_wrap;

   always_ff @(posedge Clk_i or negedge Rst_i) begin
      if (!Rst_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         tick_q  <= 1'b0;
         hs_q    <= ~ACT;
         vs_q    <= ~ACT;
         von_q   <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         tick_q  <= tick_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         von_q   <= von_d;
         fs_q    <= fs_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_d      = '0;
      h_d        = '0;
      v_d        = '0;
      fs_d       = 1'b0;
      frame_wrap = 1'b0;
      tick_now   = (div_q == DIV_MAX);
      case (state_q)
         IDLE: begin
            // Entering RUN lands on (0,0) with a fresh divider: that is a frame start.
            if (vga_io.Enable) begin
               state_d = RUN;
               fs_d    = 1'b1;
            end
         end
         RUN: begin
            if (!vga_io.Enable) begin
               state_d = IDLE;
            end else begin
               div_d = tick_now ? '0 : div_q + 1'b1;
               h_d   = h_q;
               v_d   = v_q;
               if (tick_now) begin
                  if (h_q == H_LAST) begin
                     h_d        = '0;
                     v_d        = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                     frame_wrap = (v_q == V_LAST);
                  end else begin
                     h_d = h_q + 1'b1;
                  end
               end
               fs_d = frame_wrap;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next-state counts so they align with them.
      run_d  = (state_d == RUN);
      tick_d = run_d && (div_d == DIV_MAX);
      hs_d   = (run_d && h_d >= HS_START && h_d < HS_END) ? ACT : ~ACT;
      vs_d   = (run_d && v_d >= VS_START && v_d < VS_END) ? ACT : ~ACT;
      von_d  = run_d && (h_d < H_VIS) && (v_d < V_VIS);
   end

`ifdef VGA_FRAME_COUNTER_EN
   logic [15:0] fc_q, fc_d;

   always_comb begin
      fc_d = fc_q;
      if (state_d != RUN)  fc_d = '0;
      else if (frame_wrap) fc_d = fc_q + 16'd1;
   end

   always_ff @(posedge Clk_i or negedge Rst_i) begin
      if (!Rst_i) fc_q <= '0;
      else        fc_q <= fc_d;
   end

   assign vga_io.Frame_Count = fc_q;
`else
   assign vga_io.Frame_Count = 16'd0;
`endif

   assign vga_io.Pixel_Tick  = tick_q;
   assign vga_io.HSync       = hs_q;
   assign vga_io.VSync       = vs_q;
   assign vga_io.Video_On    = von_q;
   assign vga_io.H_Count     = h_q;
   assign vga_io.V_Count     = v_q;
   assign vga_io.Frame_Start = fs_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: directed steps plus random Enable traffic, checked
// against an arithmetic model of elapsed clocks since the last IDLE->RUN edge.
module tb_vga_sync_generator;
   localparam int CD = 2;
   localparam int HV = 8, HF = 2, HS = 2, HB = 2;
   localparam int VV = 4, VF = 1, VS = 1, VB = 1;
   localparam int CW = 8;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = CD * HT * VT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   always #5 clk = ~clk;

   vga_sync_generator_if #(.COUNTER_WIDTH(CW)) vif ();
   assign vif.Enable = en;

   vga_sync_generator #(
      .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .COUNTER_WIDTH(CW), .SYNC_POLARITY(1'b0)
   ) dut (
      .Clk_i (clk),
      .Rst_i (rst_n),
      .vga_io(vif)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit running = 1'b0;
   int k = 0;

   function automatic int mh(input int kk);
      return (kk / CD) % HT;
   endfunction

   function automatic int mv(input int kk);
      return ((kk / CD) / HT) % VT;
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h (k=%0d run=%0b)", tag, obs, exp, k, running);
      end
   endtask

   task automatic check_model();
      int h, v, fc;
      logic tick, hs, vs, von, fs;
      if (!running) begin
         h = 0; v = 0; fc = 0;
         tick = 1'b0; hs = 1'b1; vs = 1'b1; von = 1'b0; fs = 1'b0;
      end else begin
         h    = mh(k);
         v    = mv(k);
         tick = ((k % CD) == CD - 1);
         hs   = !(h >= HV + HF && h < HV + HF + HS);
         vs   = !(v >= VV + VF && v < VV + VF + VS);
         von  = (h < HV) && (v < VV);
         fs   = ((k % FRAME) == 0);
`ifdef VGA_FRAME_COUNTER_EN
         fc   = (k / FRAME) % 65536;
`else
         fc   = 0;
`endif
      end
      cmp("pixel_tick",  32'(vif.Pixel_Tick),  32'(tick));
      cmp("hsync",       32'(vif.HSync),       32'(hs));
      cmp("vsync",       32'(vif.VSync),       32'(vs));
      cmp("video_on",    32'(vif.Video_On),    32'(von));
      cmp("h_count",     32'(vif.H_Count),     32'(h));
      cmp("v_count",     32'(vif.V_Count),     32'(v));
      cmp("frame_start", 32'(vif.Frame_Start), 32'(fs));
      cmp("frame_count", 32'(vif.Frame_Count), 32'(fc));
   endtask

   // One clock: advance the model on the rising edge, compare on the falling edge.
   task automatic step();
      @(posedge clk);
      if (!rst_n)       running = 1'b0;
      else if (!en)     running = 1'b0;
      else if (running) k++;
      else begin
         running = 1'b1;
         k = 0;
      end
      @(negedge clk);
      check_model();
   endtask

   initial begin
      int guard;
      // Reset held with Enable already high.
      en = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_model();
      rst_n = 1'b1;
      step();
      cmp("start_pulse", 32'(vif.Frame_Start), 32'd1);
      cmp("start_video", 32'(vif.Video_On), 32'd1);

      // A full frame and the re-pulse of Frame_Start.
      repeat (FRAME) step();
      cmp("frame_repulse", 32'(vif.Frame_Start), 32'd1);

      // Drop Enable at (5,2), then restart.
      guard = 0;
      while (!(mh(k) == 5 && mv(k) == 2) && guard < 2 * FRAME) begin
         step();
         guard++;
      end
      cmp("reach_5_2", 32'(guard < 2 * FRAME), 32'd1);
      en = 1'b0;
      step();
      cmp("idle_h", 32'(vif.H_Count), 32'd0);
      en = 1'b1;
      step();
      cmp("restart_pulse", 32'(vif.Frame_Start), 32'd1);

      // Three whole frames.
      repeat (3 * FRAME) step();
`ifdef VGA_FRAME_COUNTER_EN
      cmp("frames_3", 32'(vif.Frame_Count), 32'd3);
`else
      cmp("frames_3", 32'(vif.Frame_Count), 32'd0);
`endif

      // Asynchronous reset in the middle of HSync, between edges.
      guard = 0;
      while (mh(k) != HV + HF && guard < 2 * FRAME) begin
         step();
         guard++;
      end
      cmp("reach_hsync", 32'(vif.HSync), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      cmp("async_hsync", 32'(vif.HSync), 32'd1);
      cmp("async_h",     32'(vif.H_Count), 32'd0);
      cmp("async_v",     32'(vif.V_Count), 32'd0);
      cmp("async_von",   32'(vif.Video_On), 32'd0);
      running = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      // Random Enable traffic: mostly-on stretches, then fast toggling.
      repeat (3000) begin
         en = ($urandom_range(0, 199) != 0);
         step();
      end
      repeat (300) begin
         en = 1'(($urandom_range(0, 1)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
